// File: rtl/imm_encoder_if.sv
// Request/result handshake bundle between the instruction-patching logic and the
// immediate encoder.
interface imm_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_value;
    logic        in_force;
    logic [1:0]  in_src;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_field;
    logic [1:0]  out_imm_src;
    logic        out_error;

    modport master (
        output in_valid, in_value, in_force, in_src, out_ready,
        input  in_ready, out_valid, out_field, out_imm_src, out_error
    );

    modport slave (
        input  in_valid, in_value, in_force, in_src, out_ready,
        output in_ready, out_valid, out_field, out_imm_src, out_error
    );
endinterface

// File: rtl/imm_encoder.sv
// Immediate encoder: picks the ImmSrc format and 24-bit field that the decode-stage
// extender expands back to the requested 32-bit value, or flags it unrepresentable.
module imm_encoder #(
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    imm_encoder_if.slave         bus,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic [2:0] {StIdle, StTry00, StTry01, StTry10, StDone} state_e;

    state_e                 state_q, state_d;
    logic [31:0]            value_q, value_d;
    logic                   force_q, force_d;
    logic [23:0]            field_q, field_d;
    logic [1:0]             imm_src_q, imm_src_d;
    logic                   error_q, error_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic fit00, fit01, fit10;

    assign fit00 = (value_q[31:8] == 24'd0);
    assign fit01 = (value_q[31:12] == 20'd0);
    // Format 10 sign-extends from bit 25 and drops two zero LSBs.
    assign fit10 = (value_q[1:0] == 2'b00) && ((&value_q[31:25]) || ~(|value_q[31:25]));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            value_q   <= '0;
            force_q   <= 1'b0;
            field_q   <= '0;
            imm_src_q <= 2'b00;
            error_q   <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            value_q   <= value_d;
            force_q   <= force_d;
            field_q   <= field_d;
            imm_src_q <= imm_src_d;
            error_q   <= error_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        value_d   = value_q;
        force_d   = force_q;
        field_d   = field_q;
        imm_src_d = imm_src_q;
        error_d   = error_q;
        err_cnt_d = err_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    value_d = bus.in_value;
                    force_d = bus.in_force;
                    if (!bus.in_force) begin
                        state_d = StTry00;
                    end else begin
                        unique case (bus.in_src)
                            2'b00: state_d = StTry00;
                            2'b01: state_d = StTry01;
                            2'b10: state_d = StTry10;
                            default: begin
                                state_d   = StDone;
                                field_d   = '0;
                                imm_src_d = 2'b11;
                                error_d   = 1'b1;
                            end
                        endcase
                    end
                end
            end
            StTry00: begin
                if (fit00) begin
                    state_d   = StDone;
                    field_d   = {16'd0, value_q[7:0]};
                    imm_src_d = 2'b00;
                    error_d   = 1'b0;
                end else if (!force_q) begin
                    state_d = StTry01;
                end else begin
                    state_d   = StDone;
                    field_d   = '0;
                    imm_src_d = 2'b11;
                    error_d   = 1'b1;
                end
            end
            StTry01: begin
                if (fit01) begin
                    state_d   = StDone;
                    field_d   = {12'd0, value_q[11:0]};
                    imm_src_d = 2'b01;
                    error_d   = 1'b0;
                end else if (!force_q) begin
                    state_d = StTry10;
                end else begin
                    state_d   = StDone;
                    field_d   = '0;
                    imm_src_d = 2'b11;
                    error_d   = 1'b1;
                end
            end
            StTry10: begin
                state_d = StDone;
                if (fit10) begin
                    field_d   = value_q[25:2];
                    imm_src_d = 2'b10;
                    error_d   = 1'b0;
                end else begin
                    field_d   = '0;
                    imm_src_d = 2'b11;
                    error_d   = 1'b1;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                    if (error_q && (err_cnt_q != '1)) begin
                        err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.in_ready    = (state_q == StIdle) && !reset;
        bus.out_valid   = (state_q == StDone);
        bus.out_field   = field_q;
        bus.out_imm_src = imm_src_q;
        bus.out_error   = error_q;
        err_count       = err_cnt_q;
    end

endmodule
